// File: rtl/pipeline_exec_ctrl_pkg.sv
// Shared definitions for the pipeline execution sequencer: state encoding and
// default enabled-cycle counter width.
package pipeline_exec_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/pipeline_exec_ctrl_if.sv
// Command/status bundle between the debug unit (master) and the execution
// sequencer (slave).
interface pipeline_exec_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             i_run;
    logic             i_step;
    logic             i_stop;
    logic             i_clear;
    logic             i_halt_wb;
    logic             o_pipeline_enable;
    logic             o_running;
    logic             o_step_ack;
    logic             o_done;
    logic [CNT_W-1:0] o_cycle_count;

    modport master (
        output i_run, i_step, i_stop, i_clear, i_halt_wb,
        input  o_pipeline_enable, o_running, o_step_ack, o_done, o_cycle_count
    );

    modport slave (
        input  i_run, i_step, i_stop, i_clear, i_halt_wb,
        output o_pipeline_enable, o_running, o_step_ack, o_done, o_cycle_count
    );
endinterface

// File: rtl/pipeline_exec_ctrl.sv
// Execution sequencer: drives the shared pipeline-latch enable under debug
// command (run / single-step / stop), halts on HALT leaving MEM_WB, counts enabled cycles.
module pipeline_exec_ctrl
    import pipeline_exec_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    pipeline_exec_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_p0;
    state_t           state_nxt;
    logic             en_p0;
    logic             running_p0;
    logic             ack_p0;
    logic             done_p0;
    logic [CNT_W-1:0] cnt_p0;

    logic             en_nxt;
    logic             running_nxt;
    logic             ack_nxt;
    logic             done_nxt;
    logic             cnt_clr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // ---- stage p0: state and registered outputs ----
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_p0   <= ST_IDLE;
            en_p0      <= 1'b0;
            running_p0 <= 1'b0;
            ack_p0     <= 1'b0;
            done_p0    <= 1'b0;
        end else begin
            state_p0   <= state_nxt;
            en_p0      <= en_nxt;
            running_p0 <= running_nxt;
            ack_p0     <= ack_nxt;
            done_p0    <= done_nxt;
        end
    end

    // Stop outranks everything; DONE only leaves on stop or clear so a HALT
    // still parked in MEM_WB cannot block the clear.
    always_comb begin
        state_nxt = state_p0;
        cnt_clr   = 1'b0;
        if (bus.i_stop) begin
            state_nxt = ST_IDLE;
        end else if (state_p0 == ST_DONE) begin
            if (bus.i_clear) begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
        end else if (bus.i_halt_wb) begin
            state_nxt = ST_DONE;
        end else begin
            unique case (state_p0)
                ST_RUN:  state_nxt = ST_RUN;
                ST_STEP: state_nxt = ST_IDLE;
                ST_IDLE: begin
                    if (bus.i_run)       state_nxt = ST_RUN;
                    else if (bus.i_step) state_nxt = ST_STEP;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear right after the edge.
    always_comb begin
        en_nxt      = (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
        running_nxt = (state_nxt == ST_RUN);
        done_nxt    = (state_nxt == ST_DONE);
        ack_nxt     = (state_p0 == ST_STEP) && (state_nxt == ST_IDLE) && !bus.i_stop;
    end

    // ---- stage p0: enabled-cycle counter ----
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_p0 <= '0;
        end else if (cnt_clr) begin
            cnt_p0 <= '0;
        end else if (en_p0) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign bus.o_pipeline_enable = en_p0;
    assign bus.o_running         = running_p0;
    assign bus.o_step_ack        = ack_p0;
    assign bus.o_done            = done_p0;
    assign bus.o_cycle_count     = cnt_p0;

endmodule
